// File: rtl/step_sequencer.sv
// step_sequencer: programmable 16-step pattern sequencer for the tonal voices.
// It drives note numbers and gates for two square channels and the triangle
// channel. It also produces a free-running note clock for the effects logic.
// Optional feature macro: SEQ_SWING_EN. When defined, even steps are long
// (T + T/4) and odd steps are short (T - T/4).
module step_sequencer #(
    parameter int TICKS_PER_STEP = 6000000,
    parameter int NOTE_CLK_DIV   = 318750
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic [3:0]  i_loop_len,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_addr,
    input  logic [20:0] i_wr_data,
    output logic [5:0]  o_note_sq1,
    output logic [5:0]  o_note_sq2,
    output logic [5:0]  o_note_tri,
    output logic        o_en_sq1,
    output logic        o_en_sq2,
    output logic        o_en_tri,
    output logic [3:0]  o_step_idx,
    output logic        o_step_pulse,
    output logic        o_note_clk
);

`ifdef SEQ_SWING_EN
    localparam int TICK_MAX_LEN = TICKS_PER_STEP + TICKS_PER_STEP / 4;
`else
    localparam int TICK_MAX_LEN = TICKS_PER_STEP;
`endif
    localparam int TICK_W = $clog2(TICK_MAX_LEN);
    localparam int NC_W   = (NOTE_CLK_DIV > 1) ? $clog2(NOTE_CLK_DIV) : 1;
    localparam logic [NC_W-1:0] NC_LAST = NC_W'(NOTE_CLK_DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [20:0]       r_mem [16];
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_step_last;
    logic [3:0]        r_step_idx;
    logic [3:0]        w_next_idx;
    logic              w_load;
    logic              w_stop;
    logic [20:0]       w_word;
    logic [5:0]        r_note_sq1;
    logic [5:0]        r_note_sq2;
    logic [5:0]        r_note_tri;
    logic [2:0]        r_gates;
    logic              r_step_pulse;
    logic [NC_W-1:0]   r_nc_cnt;
    logic              r_note_clk;

    // Last tick index of the current step; swing makes it depend on step parity.
`ifdef SEQ_SWING_EN
    localparam logic [TICK_W-1:0] LAST_EVEN = TICK_W'(TICKS_PER_STEP + TICKS_PER_STEP / 4 - 1);
    localparam logic [TICK_W-1:0] LAST_ODD  = TICK_W'(TICKS_PER_STEP - TICKS_PER_STEP / 4 - 1);
    assign w_step_last = r_step_idx[0] ? LAST_ODD : LAST_EVEN;
`else
    localparam logic [TICK_W-1:0] LAST_FIXED = TICK_W'(TICKS_PER_STEP - 1);
    assign w_step_last = LAST_FIXED;
`endif

    // Step word to load. A write to the index being loaded on the same edge passes straight through.
    assign w_word = (i_wr_en && (i_wr_addr == w_next_idx)) ? i_wr_data : r_mem[w_next_idx];

    // Step memory: cleared by reset, and a write that coincides with reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Play/idle state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the load/stop decisions. Stopping wins over a step advance on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_stop       = 1'b0;
        w_next_idx   = r_step_idx;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_state_next = S_PLAY;
                    w_load       = 1'b1;
                    w_next_idx   = 4'd0;
                end
            end
            S_PLAY: begin
                if (!i_run) begin
                    w_state_next = S_IDLE;
                    w_stop       = 1'b1;
                end else if (r_tick == w_step_last) begin
                    w_load     = 1'b1;
                    w_next_idx = (r_step_idx >= i_loop_len) ? 4'd0 : r_step_idx + 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Step datapath: tick counter, step index, and note/gate outputs. A zero note field holds the previous note.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick       <= '0;
            r_step_idx   <= 4'd0;
            r_note_sq1   <= 6'd0;
            r_note_sq2   <= 6'd0;
            r_note_tri   <= 6'd0;
            r_gates      <= 3'b000;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_pulse <= w_load;
            if (w_load) begin
                r_tick     <= '0;
                r_step_idx <= w_next_idx;
                if (w_word[20:15] != 6'd0) begin
                    r_note_sq1 <= w_word[20:15];
                end
                if (w_word[14:9] != 6'd0) begin
                    r_note_sq2 <= w_word[14:9];
                end
                if (w_word[8:3] != 6'd0) begin
                    r_note_tri <= w_word[8:3];
                end
                r_gates <= w_word[2:0];
            end else if (w_stop) begin
                r_tick     <= '0;
                r_step_idx <= 4'd0;
                r_gates    <= 3'b000;
            end else if (r_state == S_PLAY) begin
                r_tick <= r_tick + TICK_W'(1);
            end
        end
    end

    // Free-running note clock. It toggles every NOTE_CLK_DIV cycles regardless of play state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nc_cnt   <= '0;
            r_note_clk <= 1'b0;
        end else if (r_nc_cnt == NC_LAST) begin
            r_nc_cnt   <= '0;
            r_note_clk <= ~r_note_clk;
        end else begin
            r_nc_cnt <= r_nc_cnt + NC_W'(1);
        end
    end

    assign o_note_sq1   = r_note_sq1;
    assign o_note_sq2   = r_note_sq2;
    assign o_note_tri   = r_note_tri;
    assign o_en_sq1     = r_gates[2];
    assign o_en_sq2     = r_gates[1];
    assign o_en_tri     = r_gates[0];
    assign o_step_idx   = r_step_idx;
    assign o_step_pulse = r_step_pulse;
    assign o_note_clk   = r_note_clk;

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Programmable 16-step pattern sequencer that drives the tonal voices of the synth. It replaces the hard-coded note case table in the top-level demo with a writable step memory, a tempo counter and a free-running note clock. Outputs connect directly to the note inputs and channel enables of the two square channels and the triangle channel. The note clock also feeds every channel's effects logic.

## Interface
- `TICKS_PER_STEP`, default 6000000: clk cycles per step (≥ 4).
- `NOTE_CLK_DIV`, default 318750: clk cycles per `note_clk` half-period (≥ 1).
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = play, 0 = stop.
- `loop_len`  in  4  index of the last step in the loop (0–15).
- `wr_en`  in  1  step-memory write strobe.
- `wr_addr`  in  4  step index to write.
- `wr_data`  in  21  step word:
  - [20:15] sq1 note
  - [14:9] sq2 note
  - [8:3] tri note
  - [2] sq1 gate
  - [1] sq2 gate
  - [0] tri gate
- `note_sq1`, `note_sq2`, `note_tri`  out  6 each  note numbers to the channels.
- `en_sq1`, `en_sq2`, `en_tri`  out  1 each  channel enables (gates).
- `step_idx`  out  4  current step.
- `step_pulse`  out  1  one-cycle strobe on every step load.
- `note_clk`  out  1  tempo/effects clock, 50% duty.

## Operation
- Step memory is 16 × 21 bits, written synchronously when `wr_en` = 1.
- Read is combinational. A write and a load to the same index on the same edge loads `wr_data` (write-through).
- States: IDLE and PLAY.
- In IDLE with `run` = 1 at an edge:
  - move to PLAY;
  - `step_idx` ← 0, tick counter ← 0;
  - step 0 is loaded;
  - `step_pulse` = 1 for the following cycle.
- In PLAY, when the tick counter reaches the step length − 1:
  - tick counter ← 0;
  - if `step_idx` ≥ `loop_len`, next index is 0; otherwise next index is `step_idx` + 1;
  - the new step is loaded and `step_pulse` = 1.
- Load rule:
  - each 6-bit note field of 0 means "hold": the corresponding note output keeps its value;
  - nonzero fields are copied to the output;
  - gate bits are always copied.
- In PLAY with `run` = 0 at an edge:
  - move to IDLE;
  - all gates ← 0, `step_idx` ← 0;
  - notes hold their last values;
  - tick counter ← 0.
- `loop_len` is sampled only at advance. Lowering it below the current `step_idx` wraps to 0 at the next advance.
- `note_clk` runs in both states and is independent of `run`. It toggles every `NOTE_CLK_DIV` cycles.
- Reset values:
  - memory all zeros;
  - all notes 0, all gates 0;
  - `step_idx` 0, `step_pulse` 0;
  - `note_clk` 0, tick and note-clock counters 0;
  - state IDLE.

## Timing
- Latency from `run` sampled high to the step-0 outputs is 1 edge. They are visible in the cycle after the sampling edge.
- Each step lasts exactly its step length in cycles. `step_pulse` is high for the first cycle of each step only.
- The stop-to-gates-low delay is 1 edge.
- `rst` overrides everything on the same edge, including mid-step and a simultaneous `wr_en`. When `rst` = 1 the write is discarded.
- `note_clk` has a half-period of `NOTE_CLK_DIV` cycles and a period of 2·`NOTE_CLK_DIV`. Its first rising edge comes `NOTE_CLK_DIV` cycles after reset release.

## Configuration
- `SEQ_SWING_EN` defined: step length alternates with `step_idx` parity.
  - Even steps last `TICKS_PER_STEP` + `TICKS_PER_STEP`/4 cycles.
  - Odd steps last `TICKS_PER_STEP` − `TICKS_PER_STEP`/4 cycles.
  - Division is an integer floor.
- `SEQ_SWING_EN` undefined: every step lasts `TICKS_PER_STEP` cycles. No swing logic is synthesised.

## Test plan
All scenarios use `TICKS_PER_STEP`=4 and `NOTE_CLK_DIV`=3.
- Reset then idle 20 cycles:
  - all outputs 0;
  - `note_clk` toggles at cycles 3, 6, 9 after release.
- Load steps 0..3 = {41,1,1,gates 111}, {0,0,13,gates 010}, {46,13,25,gates 111}, {0,0,1,gates 000}; `loop_len`=3; `run`=1.
  - Step outputs, in order: (41,1,1,111), (41,1,13,010), (46,13,25,111), (46,13,1,000).
  - Each step is held 4 cycles, then wraps to step 0.
  - `step_pulse` occurs every 4 cycles.
- During step 1, drop `run`:
  - next edge: gates 000, `step_idx` 0, notes unchanged;
  - re-raise `run`: step 0 reloads after 1 edge.
- While playing at step 2, set `loop_len`=1: the next advance goes to step 0.
- Write step 1 on the edge where step 1 loads: the new word appears on the outputs (write-through).
- Assert `rst` mid-step 2 together with `wr_en`:
  - all outputs reset;
  - memory reads back zero;
  - the written word is absent.
- `SEQ_SWING_EN` defined: steps alternate 5 and 3 cycles, measured between `step_pulse` strobes.
